ticket_vendor_fsm: RTL and testbench

Parametrised multi-station ticket vending controller. Accepts a validated journey selection, accumulates credit from four coin denominations, and on confirm issues one pulse per ticket followed by greedy five/one change pulses. Supports cancel-with-full-refund, overpay rejection and invalid-selection flagging. Sits between the keypad/coin-acceptor front end and the ticket/coin dispensers as the next-generation vending core.

---
 rtl/vendor_pkg.sv | 45 ++++
 rtl/fare_calc.sv | 48 ++++
 rtl/ticket_vendor_fsm.sv | 206 ++++++++++++++++++++
 tb/tb_ticket_vendor_fsm.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vendor_pkg.sv
// ----------------------------------------------------------------------------
// vendor_pkg
// Shared definitions for the ticket vending core: controller state encoding,
// coin-type encoding with the matching coin values, and the two change
// denominations the dispenser can pay out.
// No ports (package).
// ----------------------------------------------------------------------------
package vendor_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_TICKET,
        ST_CHANGE,
        ST_REFUND
    } state_t;

    typedef enum logic [1:0] {
        COIN_1  = 2'd0,
        COIN_5  = 2'd1,
        COIN_10 = 2'd2,
        COIN_20 = 2'd3
    } coin_t;

    localparam int COIN_VAL_1  = 1;
    localparam int COIN_VAL_5  = 5;
    localparam int COIN_VAL_10 = 10;
    localparam int COIN_VAL_20 = 20;

    // Change is paid greedily: fives first, then ones.
    localparam int CHANGE_FIVE = 5;
    localparam int CHANGE_ONE  = 1;

    // Face value of an accepted coin (fits in 5 bits).
    function automatic logic [4:0] coin_value(input coin_t c);
        case (c)
            COIN_1:  coin_value = 5'(COIN_VAL_1);
            COIN_5:  coin_value = 5'(COIN_VAL_5);
            COIN_10: coin_value = 5'(COIN_VAL_10);
            COIN_20: coin_value = 5'(COIN_VAL_20);
            default: coin_value = 5'd0;
        endcase
    endfunction

endpackage

// File: rtl/fare_calc.sv
// ----------------------------------------------------------------------------
// fare_calc
// Combinational fare lookup for a journey selection.
//   total = (BASE_FARE + |src - dest|) * count, truncated to DW bits.
//   valid = src != dest, both indices < N_STATIONS, 1 <= count <= MAX_COUNT.
// Ports:
//   src, dest  in  [SW-1:0]  journey endpoints
//   count      in  [CW-1:0]  ticket quantity
//   total      out [DW-1:0]  fare for the whole selection
//   valid      out           selection is acceptable
// ----------------------------------------------------------------------------
module fare_calc #(
    parameter int SW         = 4,
    parameter int CW         = 3,
    parameter int DW         = 8,
    parameter int BASE_FARE  = 2,
    parameter int N_STATIONS = 10,
    parameter int MAX_COUNT  = 4
) (
    input  logic [SW-1:0] src,
    input  logic [SW-1:0] dest,
    input  logic [CW-1:0] count,
    output logic [DW-1:0] total,
    output logic          valid
);

    // One extra bit so the limits compare correctly even when they equal 2^W.
    localparam logic [SW:0] LP_N_ST  = (SW+1)'(N_STATIONS);
    localparam logic [CW:0] LP_MAX_C = (CW+1)'(MAX_COUNT);

    logic [SW-1:0] w_dist;

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        w_dist = '0;
        total  = '0;
        valid  = 1'b0;

        w_dist = (src > dest) ? (src - dest) : (dest - src);
        total  = (DW'(BASE_FARE) + DW'(w_dist)) * DW'(count);
        valid  = (src != dest)
              && ({1'b0, src}   < LP_N_ST)
              && ({1'b0, dest}  < LP_N_ST)
              && (count != '0)
              && ({1'b0, count} <= LP_MAX_C);
    end

endmodule

// File: rtl/ticket_vendor_fsm.sv
// ----------------------------------------------------------------------------
// ticket_vendor_fsm
// Ticket vending controller: latches a journey selection, collects coins,
// issues one pulse per ticket on confirm and then pays change greedily as
// five/one pulses. Cancel refunds the full credit the same way.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   src, dest, count         selection, sampled on sel_valid in IDLE
//   sel_valid                selection strobe
//   coin_valid, coin_type    coin strobe and denomination (1/5/10/20)
//   done, cancel             confirm / abort strobes
//   ticket_pulse             one pulse per ticket
//   coin_one_out_pulse       one pulse per 1-unit change coin
//   coin_five_out_pulse      one pulse per 5-unit change coin
//   coin_reject_pulse        inserted coin is returned
//   sel_err, underpay        one-cycle error flags
//   busy                     controller is not IDLE
//   credit                   current credit (remaining change while paying)
// ----------------------------------------------------------------------------
module ticket_vendor_fsm
    import vendor_pkg::*;
#(
    parameter int DW         = 8,
    parameter int SW         = 4,
    parameter int N_STATIONS = 10,
    parameter int CW         = 3,
    parameter int MAX_COUNT  = 4,
    parameter int BASE_FARE  = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [SW-1:0] src,
    input  logic [SW-1:0] dest,
    input  logic [CW-1:0] count,
    input  logic          sel_valid,
    input  logic          coin_valid,
    input  logic [1:0]    coin_type,
    input  logic          done,
    input  logic          cancel,
    output logic          ticket_pulse,
    output logic          coin_one_out_pulse,
    output logic          coin_five_out_pulse,
    output logic          coin_reject_pulse,
    output logic          sel_err,
    output logic          underpay,
    output logic          busy,
    output logic [DW-1:0] credit
);

    localparam logic [DW-1:0] LP_FIVE = DW'(CHANGE_FIVE);
    localparam logic [DW-1:0] LP_ONE  = DW'(CHANGE_ONE);

    state_t        r_state;
    logic [DW-1:0] r_total;
    logic [CW-1:0] r_count;
    logic [CW-1:0] r_tick_left;   // tickets still to issue after the current one
    logic [DW-1:0] r_credit;      // holds the change still owed once paying out
    logic          r_ticket;
    logic          r_five;
    logic          r_one;
    logic          r_reject;
    logic          r_sel_err;
    logic          r_underpay;
    logic          r_busy;

    logic [DW-1:0] w_total;
    logic          w_sel_ok;
    logic [DW:0]   w_coin_sum;
    logic          w_coin_ovf;
    logic [DW-1:0] w_credit_acc;

    fare_calc #(
        .SW         (SW),
        .CW         (CW),
        .DW         (DW),
        .BASE_FARE  (BASE_FARE),
        .N_STATIONS (N_STATIONS),
        .MAX_COUNT  (MAX_COUNT)
    ) u_fare_calc (
        .src   (src),
        .dest  (dest),
        .count (count),
        .total (w_total),
        .valid (w_sel_ok)
    );

    // Credit after this cycle's coin; a coin that would overflow is refused,
    // so the decision on done/cancel always sees the post-coin credit.
    assign w_coin_sum   = {1'b0, r_credit} + (DW+1)'(coin_value(coin_t'(coin_type)));
    assign w_coin_ovf   = coin_valid && w_coin_sum[DW];
    assign w_credit_acc = (coin_valid && !w_coin_sum[DW]) ? w_coin_sum[DW-1:0] : r_credit;

    // NOTE: non-blocking assignments throughout, so every decision below uses
    // the pre-edge register values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_total     <= '0;
            r_count     <= '0;
            r_tick_left <= '0;
            r_credit    <= '0;
            r_ticket    <= 1'b0;
            r_five      <= 1'b0;
            r_one       <= 1'b0;
            r_reject    <= 1'b0;
            r_sel_err   <= 1'b0;
            r_underpay  <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_reject   <= 1'b0;
            r_sel_err  <= 1'b0;
            r_underpay <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (sel_valid) begin
                        if (w_sel_ok) begin
                            r_total  <= w_total;
                            r_count  <= count;
                            r_credit <= '0;
                            r_busy   <= 1'b1;
                            r_state  <= ST_COLLECT;
                        end else begin
                            r_sel_err <= 1'b1;
                        end
                    end
                end

                ST_COLLECT: begin
                    r_credit <= w_credit_acc;
                    r_reject <= w_coin_ovf;
                    if (cancel) begin
                        r_state <= ST_REFUND;
                    end else if (done) begin
                        if (w_credit_acc >= r_total) begin
                            // Credit now tracks the change owed.
                            r_credit    <= w_credit_acc - r_total;
                            r_ticket    <= 1'b1;
                            r_tick_left <= r_count - CW'(1);
                            r_state     <= ST_TICKET;
                        end else begin
                            r_underpay <= 1'b1;
                        end
                    end
                end

                ST_TICKET: begin
                    r_reject <= coin_valid;
                    if (r_ticket) begin
                        r_ticket <= 1'b0;
                        // Change starts right after the last ticket pulse.
                        if (r_tick_left == '0 && r_credit != '0) begin
                            r_state <= ST_CHANGE;
                            if (r_credit >= LP_FIVE) begin
                                r_five   <= 1'b1;
                                r_credit <= r_credit - LP_FIVE;
                            end else begin
                                r_one    <= 1'b1;
                                r_credit <= r_credit - LP_ONE;
                            end
                        end
                    end else if (r_tick_left != '0) begin
                        r_ticket    <= 1'b1;
                        r_tick_left <= r_tick_left - CW'(1);
                    end else begin
                        // Low cycle after the last ticket is over, no change owed.
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end

                ST_CHANGE, ST_REFUND: begin
                    r_reject <= coin_valid;
                    if (r_five || r_one) begin
                        r_five <= 1'b0;
                        r_one  <= 1'b0;
                    end else if (r_credit == '0) begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else if (r_credit >= LP_FIVE) begin
                        r_five   <= 1'b1;
                        r_credit <= r_credit - LP_FIVE;
                    end else begin
                        r_one    <= 1'b1;
                        r_credit <= r_credit - LP_ONE;
                    end
                end

                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign ticket_pulse        = r_ticket;
    assign coin_one_out_pulse  = r_one;
    assign coin_five_out_pulse = r_five;
    assign coin_reject_pulse   = r_reject;
    assign sel_err             = r_sel_err;
    assign underpay            = r_underpay;
    assign busy                = r_busy;
    assign credit              = r_credit;

endmodule

// File: tb/tb_ticket_vendor_fsm.sv
// ----------------------------------------------------------------------------
// tb_ticket_vendor_fsm
// Directed bench for ticket_vendor_fsm with default parameters.
// Inputs change and outputs are sampled 1 ns after each rising edge.
// ----------------------------------------------------------------------------
module tb_ticket_vendor_fsm;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] src = '0;
    logic [3:0] dest = '0;
    logic [2:0] count = '0;
    logic       sel_valid = 1'b0;
    logic       coin_valid = 1'b0;
    logic [1:0] coin_type = '0;
    logic       done = 1'b0;
    logic       cancel = 1'b0;
    logic       ticket_pulse;
    logic       coin_one_out_pulse;
    logic       coin_five_out_pulse;
    logic       coin_reject_pulse;
    logic       sel_err;
    logic       underpay;
    logic       busy;
    logic [7:0] credit;

    int n_tests = 0;
    int n_fail  = 0;

    ticket_vendor_fsm dut (
        .clk                 (clk),
        .rst                 (rst),
        .src                 (src),
        .dest                (dest),
        .count               (count),
        .sel_valid           (sel_valid),
        .coin_valid          (coin_valid),
        .coin_type           (coin_type),
        .done                (done),
        .cancel              (cancel),
        .ticket_pulse        (ticket_pulse),
        .coin_one_out_pulse  (coin_one_out_pulse),
        .coin_five_out_pulse (coin_five_out_pulse),
        .coin_reject_pulse   (coin_reject_pulse),
        .sel_err             (sel_err),
        .underpay            (underpay),
        .busy                (busy),
        .credit              (credit)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench in the cycle right after the strobe edge.
    task automatic select(input logic [3:0] s, input logic [3:0] d, input logic [2:0] c);
        src = s; dest = d; count = c; sel_valid = 1'b1;
        tick();
        sel_valid = 1'b0;
    endtask

    task automatic insert(input logic [1:0] t);
        coin_valid = 1'b1; coin_type = t;
        tick();
        coin_valid = 1'b0;
    endtask

    task automatic press_done();
        done = 1'b1;
        tick();
        done = 1'b0;
    endtask

    task automatic press_cancel();
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_outs"}, {24'd0, ticket_pulse, coin_one_out_pulse, coin_five_out_pulse,
                               coin_reject_pulse, sel_err, underpay, busy, 1'b0}, 32'd0);
        check({tag, "_credit"}, {24'd0, credit}, 32'd0);
    endtask

    // Observes the pay-out phase starting in cycle j=1 after the done/cancel
    // edge until busy drops. Bit j of each mask marks a pulse in cycle j.
    // A 1-unit coin is inserted in cycle 'inject' (0 = never).
    task automatic run_out(input int inject,
                           output int nt, output int nf, output int no,
                           output logic [31:0] tm, output logic [31:0] fm,
                           output logic [31:0] om, output logic [31:0] rm,
                           output int low_at, output int viol);
        logic pt, pf, po;
        nt = 0; nf = 0; no = 0;
        tm = '0; fm = '0; om = '0; rm = '0;
        low_at = -1; viol = 0;
        pt = 1'b0; pf = 1'b0; po = 1'b0;
        for (int j = 1; j <= 400; j++) begin
            if (!busy) begin
                low_at = j;
                break;
            end
            if (ticket_pulse)        begin nt++; if (j < 32) tm[j] = 1'b1; end
            if (coin_five_out_pulse) begin nf++; if (j < 32) fm[j] = 1'b1; end
            if (coin_one_out_pulse)  begin no++; if (j < 32) om[j] = 1'b1; end
            if (coin_reject_pulse && j < 32) rm[j] = 1'b1;
            if ((ticket_pulse && pt) || (coin_five_out_pulse && pf) || (coin_one_out_pulse && po))
                viol++;
            pt = ticket_pulse; pf = coin_five_out_pulse; po = coin_one_out_pulse;
            coin_valid = (j == inject);
            coin_type  = 2'd0;
            tick();
        end
        coin_valid = 1'b0;
    endtask

    initial begin
        int nt, nf, no, low_at, viol;
        logic [31:0] tm, fm, om, rm;
        logic        seen;

        // Reset state
        tick(); tick();
        check_all_zero("reset");
        rst = 1'b0;
        tick();

        // 1: total (2+3)*2 = 10, pay 20 -> 2 tickets, 2 fives; coin during TICKET rejected
        select(4'd1, 4'd4, 3'd2);
        check("t1_busy", {31'd0, busy}, 32'd1);
        insert(2'd3);
        check("t1_credit", {24'd0, credit}, 32'd20);
        press_done();
        run_out(2, nt, nf, no, tm, fm, om, rm, low_at, viol);
        check("t1_tick_mask", tm, 32'h0000_000A);
        check("t1_five_mask", fm, 32'h0000_0050);
        check("t1_one_mask",  om, 32'h0000_0000);
        check("t1_rej_mask",  rm, 32'h0000_0008);
        check("t1_busy_low",  low_at, 32'd8);
        check("t1_end_credit", {24'd0, credit}, 32'd0);
        check("t1_viol", viol, 32'd0);

        // 2: total 10, pay 10+1+1 -> 2 tickets, 2 ones
        select(4'd0, 4'd3, 3'd2);
        insert(2'd2); insert(2'd0); insert(2'd0);
        check("t2_credit", {24'd0, credit}, 32'd12);
        press_done();
        run_out(0, nt, nf, no, tm, fm, om, rm, low_at, viol);
        check("t2_tick_mask", tm, 32'h0000_000A);
        check("t2_five_cnt", nf, 32'd0);
        check("t2_one_mask", om, 32'h0000_0050);
        check("t2_busy_low", low_at, 32'd8);

        // 3: underpay with 8 against 10, then top up 5 -> change 3 ones
        select(4'd0, 4'd3, 3'd2);
        insert(2'd1); insert(2'd0); insert(2'd0); insert(2'd0);
        check("t3_credit8", {24'd0, credit}, 32'd8);
        press_done();
        check("t3_underpay_hi", {31'd0, underpay}, 32'd1);
        check("t3_busy", {31'd0, busy}, 32'd1);
        check("t3_no_ticket", {31'd0, ticket_pulse}, 32'd0);
        tick();
        check("t3_underpay_lo", {31'd0, underpay}, 32'd0);
        insert(2'd1);
        check("t3_credit13", {24'd0, credit}, 32'd13);
        press_done();
        check("t3_underpay_2", {31'd0, underpay}, 32'd0);
        run_out(0, nt, nf, no, tm, fm, om, rm, low_at, viol);
        check("t3_tick_mask", tm, 32'h0000_000A);
        check("t3_one_mask", om, 32'h0000_0150);
        check("t3_five_cnt", nf, 32'd0);
        check("t3_busy_low", low_at, 32'd10);

        // 4: cancel refunds 11 as 5+5+1, no tickets
        select(4'd1, 4'd4, 3'd2);
        insert(2'd1); insert(2'd1); insert(2'd0);
        press_cancel();
        run_out(0, nt, nf, no, tm, fm, om, rm, low_at, viol);
        check("t4_tickets", nt, 32'd0);
        check("t4_fives", nf, 32'd2);
        check("t4_ones", no, 32'd1);
        check("t4_viol", viol, 32'd0);
        check("t4_credit", {24'd0, credit}, 32'd0);
        check("t4_done", (low_at > 0) ? 32'd1 : 32'd0, 32'd1);

        // 5: invalid selections pulse sel_err and stay IDLE
        select(4'd3, 4'd3, 3'd2);
        check("t5_same_err", {31'd0, sel_err}, 32'd1);
        check("t5_same_busy", {31'd0, busy}, 32'd0);
        check("t5_same_credit", {24'd0, credit}, 32'd0);
        tick();
        check("t5_err_lo", {31'd0, sel_err}, 32'd0);
        select(4'd1, 4'd2, 3'd0);
        check("t5_cnt0_err", {31'd0, sel_err}, 32'd1);
        check("t5_cnt0_busy", {31'd0, busy}, 32'd0);
        select(4'd1, 4'd10, 3'd1);
        check("t5_range_err", {31'd0, sel_err}, 32'd1);
        select(4'd1, 4'd2, 3'd5);
        check("t5_cnt5_err", {31'd0, sel_err}, 32'd1);
        // boundary: count = MAX_COUNT and station 9 accepted; cancel with no credit
        select(4'd0, 4'd9, 3'd4);
        check("t5_max_ok_err", {31'd0, sel_err}, 32'd0);
        check("t5_max_ok_busy", {31'd0, busy}, 32'd1);
        press_cancel();
        run_out(0, nt, nf, no, tm, fm, om, rm, low_at, viol);
        check("t5_refund0", nt + nf + no, 32'd0);
        check("t5_refund0_end", (low_at > 0) ? 32'd1 : 32'd0, 32'd1);

        // 6: credit saturation at 8 bits
        select(4'd1, 4'd4, 3'd2);
        for (int i = 0; i < 12; i++) insert(2'd3);
        insert(2'd2);
        check("t6_credit250", {24'd0, credit}, 32'd250);
        insert(2'd3);
        check("t6_reject_hi", {31'd0, coin_reject_pulse}, 32'd1);
        check("t6_credit_held", {24'd0, credit}, 32'd250);
        tick();
        check("t6_reject_lo", {31'd0, coin_reject_pulse}, 32'd0);
        insert(2'd1);
        check("t6_credit255", {24'd0, credit}, 32'd255);
        check("t6_accept255", {31'd0, coin_reject_pulse}, 32'd0);
        insert(2'd0);
        check("t6_reject256", {31'd0, coin_reject_pulse}, 32'd1);
        check("t6_credit255b", {24'd0, credit}, 32'd255);
        press_cancel();
        run_out(0, nt, nf, no, tm, fm, om, rm, low_at, viol);
        check("t6_fives", nf, 32'd51);
        check("t6_ones", no, 32'd0);
        check("t6_viol", viol, 32'd0);

        // 7: reset during the second ticket pulse aborts everything
        select(4'd1, 4'd4, 3'd2);
        insert(2'd3);
        press_done();
        tick(); tick();
        check("t7_second_ticket", {31'd0, ticket_pulse}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_all_zero("t7_after_rst");
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            seen = seen | ticket_pulse | coin_five_out_pulse | coin_one_out_pulse | busy;
        end
        check("t7_quiet", {31'd0, seen}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
